// File: rtl/parent_controller.sv
`default_nettype none
// ============================================================================
// Module   : parent_controller
// Purpose  : Root stage controller for the multi-FPGA decoder. Aggregates the
//            children's busy / odd-cluster flags, drives the shared
//            decoding_start level and next_iteration toggle, and reports the
//            iteration count, cycle count and completion of each round.
// Revision : 1.0 - initial release
// ============================================================================
module parent_controller #(
   parameter int CHILD_COUNT             = 2,
   parameter int ITERATION_COUNTER_WIDTH = 8,
   parameter int MAXIMUM_ITERATIONS      = 200,
   parameter int SETTLE_CYCLES           = 6,
   parameter int PEEL_CYCLES             = 6
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               start,
   input  logic [CHILD_COUNT-1:0]             busy_from_child,
   input  logic [CHILD_COUNT-1:0]             odd_clusters_from_child,
   output logic                               decoding_start,
   output logic                               next_iteration,
   output logic [ITERATION_COUNTER_WIDTH-1:0] iteration_counter,
   output logic [31:0]                        cycle_counter,
   output logic                               result_valid,
   output logic                               iteration_overflow,
   output logic                               controller_busy
);

   // One shared down-stream counter serves SETTLE, PEEL and RELEASE, so it is
   // sized for the longer of the two wait intervals.
   localparam int c_CNT_MAX   = (SETTLE_CYCLES > PEEL_CYCLES) ? SETTLE_CYCLES : PEEL_CYCLES;
   localparam int c_CNT_WIDTH = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;

   localparam logic [c_CNT_WIDTH-1:0] c_SETTLE_LAST = c_CNT_WIDTH'(SETTLE_CYCLES - 1);
   localparam logic [c_CNT_WIDTH-1:0] c_PEEL_LAST   = c_CNT_WIDTH'(PEEL_CYCLES - 1);
   localparam logic [c_CNT_WIDTH-1:0] c_CNT_ONE     = c_CNT_WIDTH'(1);

   localparam logic [ITERATION_COUNTER_WIDTH-1:0] c_MAX_ITER = ITERATION_COUNTER_WIDTH'(MAXIMUM_ITERATIONS);
   localparam logic [ITERATION_COUNTER_WIDTH-1:0] c_ITER_ONE = ITERATION_COUNTER_WIDTH'(1);

   localparam logic [31:0] c_CYCLE_MAX = 32'hFFFF_FFFF;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      SETTLE   = 3'd1,
      EVALUATE = 3'd2,
      PEEL     = 3'd3,
      RELEASE  = 3'd4,
      DONE     = 3'd5
   } state_t;

   state_t                             r_state;
   state_t                             w_state_next;

   logic [c_CNT_WIDTH-1:0]             r_cnt;
   logic [c_CNT_WIDTH-1:0]             w_cnt_next;

   logic                               r_decoding_start;
   logic                               w_decoding_start_next;
   logic                               r_next_iteration;
   logic                               w_next_iteration_next;
   logic [ITERATION_COUNTER_WIDTH-1:0] r_iteration_counter;
   logic [ITERATION_COUNTER_WIDTH-1:0] w_iteration_counter_next;
   logic [31:0]                        r_cycle_counter;
   logic [31:0]                        w_cycle_counter_next;
   logic                               r_iteration_overflow;
   logic                               w_iteration_overflow_next;

   // Registered OR of the child flags; every decision uses only these.
   logic                               r_any_busy;
   logic                               r_any_odd;

   // Single register stage on the child flags before they reach the FSM.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_any_busy <= 1'b0;
         r_any_odd  <= 1'b0;
      end else begin
         r_any_busy <= |busy_from_child;
         r_any_odd  <= |odd_clusters_from_child;
      end
   end

   // State register plus all round-level registers computed by the next-state logic.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state              <= IDLE;
         r_cnt                <= '0;
         r_decoding_start     <= 1'b0;
         r_next_iteration     <= 1'b0;
         r_iteration_counter  <= '0;
         r_cycle_counter      <= '0;
         r_iteration_overflow <= 1'b0;
      end else begin
         r_state              <= w_state_next;
         r_cnt                <= w_cnt_next;
         r_decoding_start     <= w_decoding_start_next;
         r_next_iteration     <= w_next_iteration_next;
         r_iteration_counter  <= w_iteration_counter_next;
         r_cycle_counter      <= w_cycle_counter_next;
         r_iteration_overflow <= w_iteration_overflow_next;
      end
   end

   // Next-state and next-output logic; every register holds unless a state changes it.
   always_comb begin
      w_state_next              = r_state;
      w_cnt_next                = r_cnt;
      w_decoding_start_next     = r_decoding_start;
      w_next_iteration_next     = r_next_iteration;
      w_iteration_counter_next  = r_iteration_counter;
      w_iteration_overflow_next = r_iteration_overflow;
      w_cycle_counter_next      = r_cycle_counter;

      // Round length counts every non-idle cycle and sticks at all-ones.
      if ((r_state != IDLE) && (r_cycle_counter != c_CYCLE_MAX)) begin
         w_cycle_counter_next = r_cycle_counter + 32'd1;
      end

      case (r_state)
         IDLE: begin
            w_decoding_start_next = 1'b0;
            w_next_iteration_next = 1'b0;
            // Counters of the previous round stay visible until a new start.
            if (start) begin
               w_state_next              = SETTLE;
               w_decoding_start_next     = 1'b1;
               w_next_iteration_next     = 1'b0;
               w_iteration_counter_next  = c_ITER_ONE;
               w_cycle_counter_next      = 32'd1;
               w_iteration_overflow_next = 1'b0;
               w_cnt_next                = '0;
            end
         end

         SETTLE: begin
            // Children need time to propagate the launch before flags are trusted.
            if (r_cnt == c_SETTLE_LAST) begin
               w_state_next = EVALUATE;
               w_cnt_next   = '0;
            end else begin
               w_cnt_next = r_cnt + c_CNT_ONE;
            end
         end

         EVALUATE: begin
            if (r_any_busy) begin
               // Wait as long as any child is still working; no timeout.
               w_state_next = EVALUATE;
            end else if (r_any_odd && (r_iteration_counter < c_MAX_ITER)) begin
               // Another grow iteration: children act on the toggle edge.
               w_next_iteration_next    = ~r_next_iteration;
               w_iteration_counter_next = r_iteration_counter + c_ITER_ONE;
               w_cnt_next               = '0;
               w_state_next             = SETTLE;
            end else begin
               // Converged, or cap reached with odd clusters left over.
               if (r_any_odd) begin
                  w_iteration_overflow_next = 1'b1;
               end
               w_decoding_start_next = 1'b0;
               w_next_iteration_next = 1'b0;
               w_cnt_next            = '0;
               w_state_next          = PEEL;
            end
         end

         PEEL: begin
            // next_iteration is held low here so the children's saved toggle is clear.
            if (r_cnt == c_PEEL_LAST) begin
               w_next_iteration_next = 1'b1;
               w_cnt_next            = '0;
               w_state_next          = RELEASE;
            end else begin
               w_cnt_next = r_cnt + c_CNT_ONE;
            end
         end

         RELEASE: begin
            // Keep the peel release asserted long enough to reach every child.
            if (r_cnt == c_SETTLE_LAST) begin
               w_next_iteration_next = 1'b0;
               w_cnt_next            = '0;
               w_state_next          = DONE;
            end else begin
               w_cnt_next = r_cnt + c_CNT_ONE;
            end
         end

         DONE: begin
            w_next_iteration_next = 1'b0;
            w_state_next          = IDLE;
         end

         default: begin
            // Unreachable encodings recover to a quiet idle.
            w_state_next          = IDLE;
            w_decoding_start_next = 1'b0;
            w_next_iteration_next = 1'b0;
            w_cnt_next            = '0;
         end
      endcase
   end

   assign decoding_start     = r_decoding_start;
   assign next_iteration     = r_next_iteration;
   assign iteration_counter  = r_iteration_counter;
   assign cycle_counter      = r_cycle_counter;
   assign iteration_overflow = r_iteration_overflow;
   assign result_valid       = (r_state == DONE);
   assign controller_busy    = (r_state != IDLE);

endmodule
`default_nettype wire
